// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle shift unit.
package shift_pkg;

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 2;

    localparam logic [OP_W-1:0] OP_SLL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRL = 2'b01;
    localparam logic [OP_W-1:0] OP_SRA = 2'b11;
    localparam logic [OP_W-1:0] OP_RSV = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/result handshake between the EX stage and the shift unit.
interface shift_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [31:0]      shamt_ext;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, op, operand, shamt_ext,
        input  result, busy, done
    );

    modport slave (
        input  start, op, operand, shamt_ext,
        output result, busy, done
    );
endinterface

// File: rtl/shift_step.sv
// One shift step by k bits with zero or sign fill selected by op.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] k_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               sign_i,
    output logic [WIDTH-1:0]   data_o
);

    // SRA fill comes from the latched sign, not from data_i's current MSB
    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SLL:  data_o = data_i << k_i;
            OP_SRL:  data_o = data_i >> k_i;
            OP_SRA:  data_o = WIDTH'($signed({sign_i, data_i}) >>> k_i);
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: shifts at most STEP bits per cycle, holds result until next accept.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int unsigned STEP  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_seq_unit_if.slave bus
);

    localparam int unsigned CW = SHAMT_W + 1;

    state_e             state_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [OP_W-1:0]    op_q;
    logic               sign_q;
    logic               busy_q;
    logic               done_q;

    logic [SHAMT_W-1:0] step_k;
    logic [SHAMT_W-1:0] rem_d;
    logic [SHAMT_W-1:0] shamt_in;
    logic [WIDTH-1:0]   step_data;
    logic [26:0]        shamt_unused;

    assign shamt_in     = bus.shamt_ext[SHAMT_W-1:0];
    assign shamt_unused = bus.shamt_ext[31:SHAMT_W];

    // k = min(rem, STEP); compared one bit wider so STEP=32 stays representable
    always_comb begin
        step_k = SHAMT_W'(STEP);
        if ({1'b0, rem_q} < CW'(STEP)) begin
            step_k = rem_q;
        end
        rem_d = rem_q - step_k;
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (work_q),
        .k_i    (step_k),
        .op_i   (op_q),
        .sign_i (sign_q),
        .data_o (step_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        work_q <= bus.operand;
                        rem_q  <= shamt_in;
                        sign_q <= bus.operand[WIDTH-1];
                        // Zero amount or reserved op completes without shifting
                        if (shamt_in == '0 || bus.op == OP_RSV) begin
                            state_q  <= DONE;
                            result_q <= bus.operand;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= step_data;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q  <= DONE;
                        result_q <= step_data;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit (STEP=4) with hand-computed expectations.
module tb_shift_seq_unit;
    import shift_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   overlap;

    shift_seq_unit_if #(.WIDTH(32)) bus ();

    shift_seq_unit #(
        .STEP  (4),
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.busy && bus.done) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one request, scramble inputs, then wait (bounded) for done
    task automatic run_op(input logic [1:0] op, input logic [31:0] operand,
                          input logic [31:0] shamt, output int edges, output int busy_cyc);
        bus.start = 1'b1;
        bus.op = op;
        bus.operand = operand;
        bus.shamt_ext = shamt;
        tick();
        bus.start = 1'b0;
        bus.operand = 32'hDEAD_BEEF;
        bus.shamt_ext = 32'h0000_001F;
        bus.op = OP_SRA;
        edges = 1;
        busy_cyc = 0;
        while (!bus.done && edges < 50) begin
            if (bus.busy) busy_cyc++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = OP_SLL;
        bus.operand = '0;
        bus.shamt_ext = '0;
        tick();
        tick();
        checks++;
        if (bus.result !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h want %h", bus.result, 32'h0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sll31();
        int e, b;
        run_op(OP_SLL, 32'h0000_0001, 32'd31, e, b);
        checks++;
        if (e !== 9) begin
            errors++; $display("FAIL sll31_latency: got %0d edges want 9", e);
        end
        checks++;
        if (b !== 8) begin
            errors++; $display("FAIL sll31_busy_cycles: got %0d want 8", b);
        end
        checks++;
        if (bus.result !== 32'h8000_0000) begin
            errors++; $display("FAIL sll31_result: got %h want %h", bus.result, 32'h8000_0000);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 32'h8000_0000) begin
            errors++; $display("FAIL sll31_hold: done=%b result=%h want done=0 result=%h",
                               bus.done, bus.result, 32'h8000_0000);
        end
    endtask

    task automatic test_right_shifts();
        int e, b;
        run_op(OP_SRA, 32'h8000_00F0, 32'd4, e, b);
        checks++;
        if (e !== 2) begin
            errors++; $display("FAIL sra4_latency: got %0d edges want 2", e);
        end
        checks++;
        if (bus.result !== 32'hF800_000F) begin
            errors++; $display("FAIL sra4_result: got %h want %h", bus.result, 32'hF800_000F);
        end
        tick();
        run_op(OP_SRL, 32'h8000_00F0, 32'd4, e, b);
        checks++;
        if (bus.result !== 32'h0800_000F) begin
            errors++; $display("FAIL srl4_result: got %h want %h", bus.result, 32'h0800_000F);
        end
        tick();
    endtask

    task automatic test_shamt_mask();
        int e, b;
        run_op(OP_SLL, 32'h0000_0001, 32'hFFFF_FFE3, e, b);
        checks++;
        if (bus.result !== 32'h0000_0008) begin
            errors++; $display("FAIL mask_result: got %h want %h", bus.result, 32'h0000_0008);
        end
        checks++;
        if (e !== 2) begin
            errors++; $display("FAIL mask_latency: got %0d edges want 2", e);
        end
        tick();
    endtask

    task automatic test_passthrough();
        int e, b;
        run_op(OP_SRA, 32'h1234_5678, 32'd0, e, b);
        checks++;
        if (e !== 1 || b !== 0) begin
            errors++; $display("FAIL zero_latency: got edges=%0d busy=%0d want 1/0", e, b);
        end
        checks++;
        if (bus.result !== 32'h1234_5678) begin
            errors++; $display("FAIL zero_result: got %h want %h", bus.result, 32'h1234_5678);
        end
        tick();
        run_op(OP_RSV, 32'h1234_5678, 32'd5, e, b);
        checks++;
        if (e !== 1 || b !== 0) begin
            errors++; $display("FAIL rsv_latency: got edges=%0d busy=%0d want 1/0", e, b);
        end
        checks++;
        if (bus.result !== 32'h1234_5678) begin
            errors++; $display("FAIL rsv_result: got %h want %h", bus.result, 32'h1234_5678);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int e;
        bus.start = 1'b1;
        bus.op = OP_SRL;
        bus.operand = 32'hFFFF_FFFF;
        bus.shamt_ext = 32'd20;
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy: got %b want 1", bus.busy);
        end
        // start while busy must be ignored
        bus.op = OP_SLL;
        bus.operand = 32'h0000_0001;
        bus.shamt_ext = 32'd0;
        tick();
        bus.start = 1'b0;
        e = 2;
        while (!bus.done && e < 50) begin
            tick();
            e++;
        end
        checks++;
        if (e !== 6 || bus.result !== 32'h0000_0FFF) begin
            errors++; $display("FAIL b2b_first: edges=%0d result=%h want 6/%h",
                               e, bus.result, 32'h0000_0FFF);
        end
        // new start in the done cycle
        bus.start = 1'b1;
        bus.op = OP_SLL;
        bus.operand = 32'h0000_0003;
        bus.shamt_ext = 32'd2;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", bus.busy, bus.done);
        end
        e = 1;
        while (!bus.done && e < 50) begin
            tick();
            e++;
        end
        checks++;
        if (e !== 2 || bus.result !== 32'h0000_000C) begin
            errors++; $display("FAIL b2b_second: edges=%0d result=%h want 2/%h",
                               e, bus.result, 32'h0000_000C);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int dones;
        bus.start = 1'b1;
        bus.op = OP_SLL;
        bus.operand = 32'h0000_0001;
        bus.shamt_ext = 32'd31;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.result !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_state: result=%h busy=%b done=%b want 0/0/0",
                               bus.result, bus.busy, bus.done);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            errors++; $display("FAIL abort_result_hold: got %h want %h", bus.result, 32'h0);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap !== 0) begin
            errors++; $display("FAIL busy_done_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        overlap = 0;
        test_reset();
        test_sll31();
        test_right_shifts();
        test_shamt_mask();
        test_passthrough();
        test_back_to_back();
        test_reset_abort();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
Multi-cycle shift execution unit in the MiniSys1A EX stage. It sits directly downstream of the 5-bit shift-amount zero-extender and consumes its 32-bit output as the shift amount for SLL/SRL/SRA. It also accepts the register-sourced amount for SLLV/SRLV/SRAV. Each cycle it shifts by at most STEP bits, handing a held 32-bit result to the EX result mux with a start/busy/done handshake.

Parameters:
STEP, 4, maximum bits shifted per cycle. Legal values 1, 2, 4, 8, 16, 32.
WIDTH, 32, datapath width. Fixed at 32 for MiniSys1A.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request strobe. Sampled only when not busy.
op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
operand  input  32  value to be shifted (rt).
shamt_ext  input  32  extended shift amount. Only bits [4:0] are used; bits [31:5] are ignored.
result  output  32  shift result. Held stable until the next accepted start.
busy  output  1  high while in state SHIFT.
done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset: when rst_n is sampled low at a clk edge:
  - state becomes IDLE; result=32'h0, busy=0, done=0;
  - internal remaining count and latched op are cleared.
  - This applies in any state. An operation in progress is aborted with no done pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE or DONE, start=1 (accept):
  - latch op and operand into the working register;
  - rem <= shamt_ext[4:0];
  - sign <= operand[31].
  - If rem is 0 or op is 10, go to DONE with result=operand. Otherwise go to SHIFT.
- IDLE or DONE, start=0: go to (or stay in) IDLE. done is cleared.
- SHIFT, each edge:
  - k = min(rem, STEP); shift the working register by k;
  - SLL fills with 0; SRL fills with 0; SRA fills with the latched sign;
  - rem <= rem - k;
  - if rem - k == 0, go to DONE and update result.
  - start is ignored while in SHIFT. No queueing.
- DONE: done=1 for exactly one cycle, busy=0. The next edge goes to IDLE, or accepts a new start back-to-back.
- Latency: done is high in the cycle 1 + ceil(shamt/STEP) edges after the accepting edge.
  - shamt=0: done appears after 1 edge.
  - shamt=31 with STEP=4: 9 edges.
- Input stability: result depends only on values latched at the accept edge. operand, op and shamt_ext may change freely afterwards.
- Shifting by 31 is the maximum. There is no wrap-around and no modulo beyond the 5-bit field.
- busy and done are never high in the same cycle.

Decomposition:
- Package shift_pkg holds:
  - op code constants OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_RSV=2'b10;
  - the state encoding IDLE/SHIFT/DONE;
  - SHAMT_W=5.
- One combinational sub-module, shift_step. Inputs: data, k, op, sign. Output: the data shifted once by k with the correct fill.
- The top level holds only the FSM, counters and registers.

Test Plan:
- SLL, operand=32'h0000_0001, shamt_ext=32'd31, STEP=4 -> busy high for 8 cycles; done 9 edges after accept; result=32'h8000_0000.
- SRA, operand=32'h8000_00F0, shamt_ext=32'd4 -> done after 2 edges; result=32'hF800_000F. Repeat with SRL -> result=32'h0800_000F.
- SLL, operand=32'h0000_0001, shamt_ext=32'hFFFF_FFE3 -> upper bits ignored, shamt=3; result=32'h0000_0008.
- shamt_ext=0, any op; and op=2'b10 with shamt_ext=5 -> done after 1 edge; result equals operand (e.g. 32'h1234_5678); busy never asserted.
- During a SRL of 32'hFFFF_FFFF by 20, pulse start with new operand=32'h1 -> ignored; result=32'h0000_0FFF. Then a back-to-back start in the DONE cycle is accepted.
- During a 31-bit shift, drive rst_n=0 for one edge -> next cycle result=0, busy=0, done=0; no done pulse follows.
